// File: rtl/fir_operand_feeder_if.sv
// ---------------------------------------------------------------------------
// fir_operand_feeder_if
// Bundles the sample-input handshake and the operand-pair output bus of the
// FIR operand feeder.
//   din, din_valid  : sample stream into the feeder
//   din_ready       : feeder can take a sample this cycle
//   sum1, sum2      : symmetric operand pair for the downstream pre-adders
//   pair_valid      : qualifies sum1/sum2/pair_idx/pair_last
//   pair_idx        : tap-pair index k of the presented pair
//   pair_last       : marks the final pair of a burst
// Modports: master = the feeder itself, slave = whoever drives samples and
// consumes pairs.
// ---------------------------------------------------------------------------
interface fir_operand_feeder_if #(
  parameter int N    = 8,
  parameter int TAPS = 8
);
  localparam int IDX_W = (TAPS / 2 > 1) ? $clog2(TAPS / 2) : 1;

  logic [N-1:0]     din;
  logic             din_valid;
  logic             din_ready;
  logic [N-1:0]     sum1;
  logic [N-1:0]     sum2;
  logic             pair_valid;
  logic [IDX_W-1:0] pair_idx;
  logic             pair_last;

  modport master (
    input  din, din_valid,
    output din_ready, sum1, sum2, pair_valid, pair_idx, pair_last
  );

  modport slave (
    output din, din_valid,
    input  din_ready, sum1, sum2, pair_valid, pair_idx, pair_last
  );
endinterface

// File: rtl/fir_operand_feeder.sv
// ---------------------------------------------------------------------------
// fir_operand_feeder
// Keeps the most recent TAPS samples in a circular buffer and, for every
// accepted sample, issues TAPS/2 symmetric operand pairs
// (x[n-k], x[n-(TAPS-1-k)]) for a linear-phase FIR pre-add stage.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fir_operand_feeder_if.master (sample handshake + pair outputs)
// One sample is taken per TAPS/2+1 cycles; din_ready is high only in IDLE.
// ---------------------------------------------------------------------------
module fir_operand_feeder #(
  parameter int N    = 8,
  parameter int TAPS = 8
) (
  input logic                  clk,
  input logic                  rst,
  fir_operand_feeder_if.master bus
);

  localparam int PTR_W = $clog2(TAPS);
  localparam int PAIRS = TAPS / 2;
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [PTR_W-1:0] HEAD_RST = PTR_W'(TAPS - 1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(PAIRS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [N-1:0]     buf_q [TAPS];
  logic [N-1:0]     buf_d [TAPS];
  logic [N-1:0]     sum1_q, sum1_d;
  logic [N-1:0]     sum2_q, sum2_d;
  logic             pair_valid_q, pair_valid_d;
  logic [IDX_W-1:0] pair_idx_q, pair_idx_d;
  logic             pair_last_q, pair_last_d;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd1_ptr;
  logic [PTR_W-1:0] rd2_ptr;

  // Pointer increment modulo TAPS; explicit wrap keeps non-power-of-two
  // lengths correct.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == HEAD_RST) ? '0 : p + PTR_W'(1);
  endfunction

  // (p - off) modulo TAPS, with off in 0..TAPS-1.
  function automatic logic [PTR_W-1:0] ptr_back(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] off);
    logic [PTR_W:0] wide;
    if (p >= off) wide = {1'b0, p} - {1'b0, off};
    else          wide = {1'b0, p} + (PTR_W + 1)'(TAPS) - {1'b0, off};
    return wide[PTR_W-1:0];
  endfunction

  always_comb begin
    wr_ptr  = ptr_next(head_q);
    rd1_ptr = ptr_back(head_q, PTR_W'(k_q));
    rd2_ptr = ptr_back(head_q, HEAD_RST - PTR_W'(k_q));

    state_d      = state_q;
    head_d       = head_q;
    k_d          = k_q;
    buf_d        = buf_q;
    sum1_d       = sum1_q;
    sum2_d       = sum2_q;
    pair_valid_d = 1'b0;
    pair_idx_d   = pair_idx_q;
    pair_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          head_d         = wr_ptr;
          buf_d[wr_ptr]  = bus.din;
          k_d            = '0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        // Buffer is read before any new write, so the pair always sees the
        // history of the sample that started this burst.
        sum1_d       = buf_q[rd1_ptr];
        sum2_d       = buf_q[rd2_ptr];
        pair_valid_d = 1'b1;
        pair_idx_d   = k_q;
        pair_last_d  = (k_q == K_LAST);
        if (k_q == K_LAST) state_d = IDLE;
        else               k_d     = k_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: control, history and output operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      head_q       <= HEAD_RST;
      k_q          <= '0;
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
      sum1_q       <= '0;
      sum2_q       <= '0;
      pair_valid_q <= 1'b0;
      pair_idx_q   <= '0;
      pair_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      k_q          <= k_d;
      buf_q        <= buf_d;
      sum1_q       <= sum1_d;
      sum2_q       <= sum2_d;
      pair_valid_q <= pair_valid_d;
      pair_idx_q   <= pair_idx_d;
      pair_last_q  <= pair_last_d;
    end
  end

  assign bus.din_ready  = (state_q == IDLE);
  assign bus.sum1       = sum1_q;
  assign bus.sum2       = sum2_q;
  assign bus.pair_valid = pair_valid_q;
  assign bus.pair_idx   = pair_idx_q;
  assign bus.pair_last  = pair_last_q;

endmodule
